// File: rtl/and_32_if.sv
// ---------------------------------------------------------------------------
// and_32_if
//   Operand/result bundle for the and_32 bitwise AND unit.
//
//   Signals
//     X          operand A                               (master -> slave)
//     Y          operand B                               (master -> slave)
//     result     registered X & Y                        (slave -> master)
//     zero       registered flag, 1 when X & Y == 0      (slave -> master)
//     ones_count registered popcount of X & Y            (slave -> master)
//
//   Modports
//     master  the operand source; drives X/Y and observes the results
//     slave   the AND unit itself
// ---------------------------------------------------------------------------
interface and_32_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [CNT_W-1:0] ones_count;

    modport master (
        output X,
        output Y,
        input  result,
        input  zero,
        input  ones_count
    );

    modport slave (
        input  X,
        input  Y,
        output result,
        output zero,
        output ones_count
    );
endinterface : and_32_if

// File: rtl/and_32.sv
// ---------------------------------------------------------------------------
// and_32
//   Bitwise AND unit for the AND/ANDI result path of the ALU. Computes
//   X & Y together with zero and population-count status and registers all
//   three on the rising edge of clk. Fully pipelined, one cycle latency,
//   one result per cycle, no handshake.
//
//   Ports
//     clk    system clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset; forces result=0, zero=1,
//            ones_count=0 and takes priority over operand capture
//     bus    and_32_if.slave: X, Y in; result, zero, ones_count out
//
//   Parameters
//     WIDTH  operand/result width, any value >= 2
//     CNT_W  width of ones_count, must be $clog2(WIDTH)+1
// ---------------------------------------------------------------------------
module and_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    and_32_if.slave       bus
);

    // Popcount tree geometry: leaves are padded up to a power of two so every
    // level halves cleanly. Nodes are stored heap-style in one flat array:
    // node k has children 2k+1 and 2k+2, leaves occupy [LEAVES-1 : 2*LEAVES-2],
    // and node 0 is the root (the total count).
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [WIDTH-1:0] and_w;
    logic [CNT_W-1:0] node [NODES];

    assign and_w = bus.X & bus.Y;

    // Leaf level: one bit of X & Y each, zero-extended; padding leaves are 0.
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < WIDTH) begin : g_bit
            assign node[LEAVES - 1 + i] = {{(CNT_W-1){1'b0}}, and_w[i]};
        end else begin : g_pad
            assign node[LEAVES - 1 + i] = '0;
        end
    end

    // One adder stage per tree level, root level first. Every partial sum is
    // bounded by WIDTH, so CNT_W bits never overflow at any level.
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        for (genvar k = (1 << l) - 1; k < (2 << l) - 1; k++) begin : g_node
            assign node[k] = node[2*k + 1] + node[2*k + 2];
        end
    end

    // All three outputs come from the same operand pair and the same edge, so
    // they stay mutually consistent, including the first cycle after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.result     <= '0;
            bus.zero       <= 1'b1;
            bus.ones_count <= '0;
        end else begin
            bus.result     <= and_w;
            bus.zero       <= ~|and_w;
            bus.ones_count <= node[0];
        end
    end

endmodule : and_32

// File: tb/tb_and_32.sv
// ---------------------------------------------------------------------------
// tb_and_32
//   Self-checking bench for and_32: directed vectors with hand-computed
//   expectations, back-to-back streaming, mid-stream reset, and random pairs
//   checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_and_32;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    and_32_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    and_32 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int ref_pop(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // Compare all three outputs against explicit expected values.
    task automatic check_out(input string tag, input logic [WIDTH-1:0] exp_r,
                             input logic exp_z, input int exp_c);
        check({tag, ".result"},     64'(bus.result),     64'(exp_r));
        check({tag, ".zero"},       64'(bus.zero),       64'(exp_z));
        check({tag, ".ones_count"}, 64'(bus.ones_count), 64'(exp_c));
    endtask

    // Drive one pair at the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic apply(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        bus.X = x;
        bus.Y = y;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] sx [6];
    logic [WIDTH-1:0] sy [6];
    logic [WIDTH-1:0] px, py, rx, ry, m;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.X = 32'h1234_5678;
        bus.Y = 32'hFFFF_FFFF;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 32'h0, 1'b1, 0);

        @(negedge clk);
        rst_n = 1'b1;

        apply(32'h0000_0001, 32'h0000_0002);
        check_out("t1", 32'h0000_0000, 1'b1, 0);
        apply(32'h0000_0000, 32'h0000_0001);
        check_out("t2", 32'h0000_0000, 1'b1, 0);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_out("t3", 32'hFFFF_FFFF, 1'b0, 32);
        apply(32'h5555_5555, 32'hAAAA_AAAA);
        check_out("t4a", 32'h0000_0000, 1'b1, 0);
        apply(32'hF0F0_FFFF, 32'h0FF0_F00F);
        check_out("t4b", 32'h00F0_F00F, 1'b0, 12);
        apply(32'h8000_0000, 32'hC000_0000);
        check_out("msb", 32'h8000_0000, 1'b0, 1);

        // Operand changes between edges must not reach the outputs.
        @(negedge clk);
        bus.X = 32'hFFFF_0000;
        #2;
        check_out("hold", 32'h8000_0000, 1'b0, 1);

        // Back-to-back stream: new pair every edge, each checked one edge later.
        sx[0] = 32'h0000_000F; sy[0] = 32'h0000_00FF;
        sx[1] = 32'hDEAD_BEEF; sy[1] = 32'hFFFF_0000;
        sx[2] = 32'h1111_1111; sy[2] = 32'h3333_3333;
        sx[3] = 32'h7FFF_FFFF; sy[3] = 32'hFFFF_FFFE;
        sx[4] = 32'h0F0F_0F0F; sy[4] = 32'hF0F0_F0F0;
        sx[5] = 32'hA5A5_A5A5; sy[5] = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.X = sx[0];
        bus.Y = sy[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m = sx[i] & sy[i];
            check_out($sformatf("b2b%0d", i), m, (m == '0), ref_pop(m));
            if (i < 5) begin
                bus.X = sx[i+1];
                bus.Y = sy[i+1];
            end
        end
        // Hand-computed spot checks on two of the stream entries.
        check(  "b2b_hand1", 64'(sx[1] & sy[1]), 64'hDEAD_0000);
        check(  "b2b_hand3", 64'(ref_pop(sx[3] & sy[3])), 64'd30);

        // Mid-stream reset while result is all ones.
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_out("pre_rst", 32'hFFFF_FFFF, 1'b0, 32);
        @(negedge clk);
        rst_n = 1'b0;
        bus.X = 32'h0000_FFFF;
        bus.Y = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        check_out("mid_rst", 32'h0, 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.X = 32'h8000_0001;
        bus.Y = 32'h8000_0001;
        @(posedge clk);
        #1;
        check_out("post_rst", 32'h8000_0001, 1'b0, 2);

        // Random streaming pairs against the model.
        @(negedge clk);
        px = $urandom;
        py = $urandom;
        bus.X = px;
        bus.Y = py;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            m = px & py;
            check_out("rand", m, (m == '0), ref_pop(m));
            rx = $urandom;
            ry = $urandom;
            if (i % 7 == 0) ry = ry & ~rx;
            px = rx;
            py = ry;
            bus.X = px;
            bus.Y = py;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_and_32
